gcd_req_sequencer: RTL and testbench

Upstream command stage for the GCD engine (`gcd_top`). It accepts operand pairs on a valid/ready stream and buffers them in a small FIFO. It issues them one at a time to the core via a `start` pulse, waits for `done`, and returns each result (with its operands) on a valid/ready result stream. Zero operands are resolved locally without invoking the core.

---
 rtl/gcd_pkg.sv | 14 +
 rtl/gcd_fifo.sv | 70 +++++++
 rtl/gcd_req_sequencer.sv | 109 ++++++++++
 tb/tb_gcd_req_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD request sequencer and its FIFO.
`timescale 1ns/1ps
package gcd_pkg;

  localparam int OP_SZ = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } gcd_seq_state_t;

endpackage

// File: rtl/gcd_fifo.sv
// Small power-of-two FIFO holding operand pairs.
// Count, full and empty are registered so that consumers see no combinational path from pop.
`timescale 1ns/1ps
module gcd_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW:0]      count_q, count_d;
  logic             full_q, empty_q;
  logic             doPush, doPop;

  assign doPush = push_i && !full_q;
  assign doPop  = pop_i && !empty_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (doPush) wptr_d = wptr_q + PW'(1);
    if (doPop)  rptr_d = rptr_q + PW'(1);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= (count_d == (PW+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset; the head is only meaningful while not empty.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/gcd_req_sequencer.sv
// Buffers operand pairs, issues them one at a time to the GCD core and returns results.
// Pairs with a zero operand are answered locally as a|b without starting the core.
`timescale 1ns/1ps
module gcd_req_sequencer
  import gcd_pkg::*;
#(
  parameter int op_sz = OP_SZ,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [op_sz-1:0] in_a,
  input  logic [op_sz-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [op_sz-1:0] out_a,
  output logic [op_sz-1:0] out_b,
  output logic [op_sz-1:0] out_res,
  output logic [op_sz-1:0] gcd_a,
  output logic [op_sz-1:0] gcd_b,
  output logic             gcd_start,
  input  logic [op_sz-1:0] gcd_res,
  input  logic             gcd_done,
  output logic             busy
);

  gcd_seq_state_t            state_q, state_d;
  logic [op_sz-1:0]          res_q, res_d;
  logic [2*op_sz-1:0]        head;
  logic [op_sz-1:0]          headA, headB;
  logic [$clog2(DEPTH):0]    fifoCount;
  logic                      fifoFull, fifoEmpty;
  logic                      popResult;

  assign popResult = (state_q == RESP) && out_ready;

  gcd_fifo #(
    .WIDTH (2*op_sz),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (in_valid),
    .push_data_i ({in_a, in_b}),
    .pop_i       (popResult),
    .head_o      (head),
    .count_o     (fifoCount),
    .full_o      (fifoFull),
    .empty_o     (fifoEmpty)
  );

  assign headA = head[2*op_sz-1:op_sz];
  assign headB = head[op_sz-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
    end
  end

  // gcd_done only matters in WAIT; anything seen elsewhere is a stale or spurious pulse.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          if (headA == '0 || headB == '0) begin
            res_d   = headA | headB;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (gcd_done) begin
          res_d   = gcd_res;
          state_d = RESP;
        end
      end
      RESP: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gcd_start = (state_q == ISSUE);
    out_valid = (state_q == RESP);
    busy      = (state_q != IDLE) || (fifoCount != '0);
  end

  assign in_ready = !fifoFull;
  assign gcd_a    = headA;
  assign gcd_b    = headB;
  assign out_a    = headA;
  assign out_b    = headB;
  assign out_res  = res_q;

endmodule

// File: tb/tb_gcd_req_sequencer.sv
// Directed testbench for gcd_req_sequencer with a behavioural multi-cycle GCD core.
`timescale 1ns/1ps
module tb_gcd_req_sequencer;

  localparam int LAT = 4;

  logic       clk, rst;
  logic       inValid, inReady;
  logic [7:0] inA, inB;
  logic       outValid, outReady;
  logic [7:0] outA, outB, outRes;
  logic [7:0] gcdA, gcdB, gcdRes;
  logic       gcdStart, gcdDone, busy;

  logic       coreDone, coreActive, spurDone;
  logic [7:0] coreRes;
  int         coreCnt;
  int         startCount = 0;
  int         tests = 0;
  int         fails = 0;

  gcd_req_sequencer #(.op_sz(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_a      (inA),
    .in_b      (inB),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_a     (outA),
    .out_b     (outB),
    .out_res   (outRes),
    .gcd_a     (gcdA),
    .gcd_b     (gcdB),
    .gcd_start (gcdStart),
    .gcd_res   (gcdRes),
    .gcd_done  (gcdDone),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gcdFn(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Core model: answers LAT cycles after start; spurious pulses carry a bogus result.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      coreDone   <= 1'b0;
      coreActive <= 1'b0;
      coreCnt    <= 0;
      coreRes    <= '0;
    end else begin
      coreDone <= 1'b0;
      if (gcdStart) begin
        coreActive <= 1'b1;
        coreCnt    <= LAT;
        coreRes    <= gcdFn(gcdA, gcdB);
      end else if (coreActive) begin
        if (coreCnt == 1) begin
          coreDone   <= 1'b1;
          coreActive <= 1'b0;
        end
        coreCnt <= coreCnt - 1;
      end
    end
  end

  assign gcdDone = coreDone | spurDone;
  assign gcdRes  = coreDone ? coreRes : 8'hAA;

  always @(posedge clk) if (gcdStart) startCount <= startCount + 1;

  task automatic pushPair(input logic [7:0] a, input logic [7:0] b);
    inValid = 1'b1;
    inA = a;
    inB = b;
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    tests++; if (inReady !== 1'b1) begin fails++; $display("[TB] FAIL reset.in_ready: got %b expected 1", inReady); end
    tests++; if (outValid !== 1'b0) begin fails++; $display("[TB] FAIL reset.out_valid: got %b expected 0", outValid); end
    tests++; if (gcdStart !== 1'b0) begin fails++; $display("[TB] FAIL reset.gcd_start: got %b expected 0", gcdStart); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset.busy: got %b expected 0", busy); end
    tests++; if (outRes !== 8'd0) begin fails++; $display("[TB] FAIL reset.out_res: got %0d expected 0", outRes); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0 || outValid !== 1'b0) begin fails++; $display("[TB] FAIL reset.release_idle: busy=%b out_valid=%b expected 0/0", busy, outValid); end
  endtask

  task automatic test_single_pair();
    int s0;
    outReady = 1'b1;
    s0 = startCount;
    pushPair(8'd12, 8'd18);
    tests++; if (gcdStart !== 1'b0) begin fails++; $display("[TB] FAIL single.start_early: got %b expected 0", gcdStart); end
    @(posedge clk); #1;
    tests++; if (gcdStart !== 1'b1) begin fails++; $display("[TB] FAIL single.start_pulse: got %b expected 1", gcdStart); end
    tests++; if (gcdA !== 8'd12 || gcdB !== 8'd18) begin fails++; $display("[TB] FAIL single.core_operands: got %0d,%0d expected 12,18", gcdA, gcdB); end
    @(posedge clk); #1;
    tests++; if (gcdStart !== 1'b0) begin fails++; $display("[TB] FAIL single.start_width: got %b expected 0", gcdStart); end
    for (int c = 0; c < 40 && !outValid; c++) begin @(posedge clk); #1; end
    tests++;
    if (!outValid) begin
      fails++; $display("[TB] FAIL single.timeout: got out_valid=0 expected 1");
    end else if (outRes !== 8'd6 || outA !== 8'd12 || outB !== 8'd18) begin
      fails++; $display("[TB] FAIL single.result: got res=%0d a=%0d b=%0d expected 6,12,18", outRes, outA, outB);
    end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0 || outValid !== 1'b0) begin fails++; $display("[TB] FAIL single.busy_after: busy=%b out_valid=%b expected 0/0", busy, outValid); end
    tests++; if (startCount - s0 !== 1) begin fails++; $display("[TB] FAIL single.start_count: got %0d expected 1", startCount - s0); end
  endtask

  task automatic test_zero_bypass();
    logic [7:0] va [3] = '{8'd0, 8'd0, 8'd7};
    logic [7:0] vb [3] = '{8'd9, 8'd0, 8'd0};
    logic [7:0] ve [3] = '{8'd9, 8'd0, 8'd7};
    int s0;
    outReady = 1'b1;
    s0 = startCount;
    for (int i = 0; i < 3; i++) begin
      pushPair(va[i], vb[i]);
      if (i == 0) begin
        tests++; if (outValid !== 1'b0) begin fails++; $display("[TB] FAIL zero.early_valid: got %b expected 0", outValid); end
      end
      @(posedge clk); #1;
      tests++;
      if (outValid !== 1'b1 || outRes !== ve[i]) begin
        fails++; $display("[TB] FAIL zero.result%0d: got valid=%b res=%0d expected 1,%0d", i, outValid, outRes, ve[i]);
      end
    end
    @(posedge clk); #1;
    tests++; if (startCount - s0 !== 0) begin fails++; $display("[TB] FAIL zero.no_start: got %0d starts expected 0", startCount - s0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL zero.busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_full_fifo();
    logic [7:0] va [5] = '{8'd6, 8'd15, 8'd9, 8'd8, 8'd5};
    logic [7:0] vb [5] = '{8'd4, 8'd10, 8'd3, 8'd12, 8'd5};
    logic [7:0] ve [4] = '{8'd2, 8'd5, 8'd3, 8'd4};
    int s0, k;
    outReady = 1'b0;
    s0 = startCount;
    for (int i = 0; i < 5; i++) begin
      inValid = 1'b1; inA = va[i]; inB = vb[i];
      tests++;
      if (inReady !== (i < 4)) begin fails++; $display("[TB] FAIL full.in_ready%0d: got %b expected %b", i, inReady, (i < 4)); end
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    for (int c = 0; c < 40 && !outValid; c++) begin @(posedge clk); #1; end
    tests++;
    if (!outValid || outA !== va[0] || outRes !== ve[0]) begin
      fails++; $display("[TB] FAIL full.first: got valid=%b a=%0d res=%0d expected 1,%0d,%0d", outValid, outA, outRes, va[0], ve[0]);
    end
    outReady = 1'b1;
    #1;
    tests++; if (inReady !== 1'b0) begin fails++; $display("[TB] FAIL full.ready_same_cycle: got %b expected 0", inReady); end
    @(posedge clk); #1;
    tests++; if (inReady !== 1'b1) begin fails++; $display("[TB] FAIL full.ready_after_pop: got %b expected 1", inReady); end
    k = 1;
    for (int c = 0; c < 80 && k < 4; c++) begin
      if (outValid) begin
        tests++;
        if (outA !== va[k] || outB !== vb[k] || outRes !== ve[k]) begin
          fails++; $display("[TB] FAIL full.order%0d: got %0d,%0d->%0d expected %0d,%0d->%0d", k, outA, outB, outRes, va[k], vb[k], ve[k]);
        end
        k++;
      end
      @(posedge clk); #1;
    end
    tests++; if (k !== 4) begin fails++; $display("[TB] FAIL full.drain_count: got %0d expected 4", k); end
    repeat (10) begin @(posedge clk); #1; end
    tests++; if (outValid !== 1'b0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL full.fifth_dropped: valid=%b busy=%b expected 0/0", outValid, busy); end
    tests++; if (startCount - s0 !== 4) begin fails++; $display("[TB] FAIL full.start_count: got %0d expected 4", startCount - s0); end
  endtask

  task automatic test_backpressure();
    logic [7:0] va [3] = '{8'd48, 8'd20, 8'd9};
    logic [7:0] ve [3] = '{8'd12, 8'd4, 8'd3};
    int s0, k;
    outReady = 1'b0;
    pushPair(8'd48, 8'd36);
    pushPair(8'd20, 8'd8);
    pushPair(8'd9, 8'd6);
    for (int c = 0; c < 40 && !outValid; c++) begin @(posedge clk); #1; end
    s0 = startCount;
    for (int c = 0; c < 10; c++) begin
      tests++;
      if (outValid !== 1'b1 || outRes !== 8'd12 || outA !== 8'd48 || outB !== 8'd36) begin
        fails++; $display("[TB] FAIL bp.hold%0d: got valid=%b %0d,%0d->%0d expected 1 48,36->12", c, outValid, outA, outB, outRes);
      end
      @(posedge clk); #1;
    end
    tests++; if (startCount !== s0 || gcdStart !== 1'b0) begin fails++; $display("[TB] FAIL bp.no_start: got %0d new starts expected 0", startCount - s0); end
    outReady = 1'b1;
    k = 0;
    for (int c = 0; c < 80 && k < 3; c++) begin
      if (outValid) begin
        tests++;
        if (outA !== va[k] || outRes !== ve[k]) begin
          fails++; $display("[TB] FAIL bp.order%0d: got a=%0d res=%0d expected %0d,%0d", k, outA, outRes, va[k], ve[k]);
        end
        k++;
      end
      @(posedge clk); #1;
    end
    tests++; if (k !== 3) begin fails++; $display("[TB] FAIL bp.drain_count: got %0d expected 3", k); end
  endtask

  task automatic test_reset_mid();
    outReady = 1'b1;
    pushPair(8'd30, 8'd12);
    pushPair(8'd25, 8'd15);
    pushPair(8'd27, 8'd18);
    tests++; if (busy !== 1'b1 || outValid !== 1'b0) begin fails++; $display("[TB] FAIL rstmid.pre: busy=%b valid=%b expected 1/0", busy, outValid); end
    #2 rst = 1'b0;
    #1;
    tests++; if (outValid !== 1'b0) begin fails++; $display("[TB] FAIL rstmid.out_valid: got %b expected 0", outValid); end
    tests++; if (gcdStart !== 1'b0) begin fails++; $display("[TB] FAIL rstmid.gcd_start: got %b expected 0", gcdStart); end
    tests++; if (inReady !== 1'b1) begin fails++; $display("[TB] FAIL rstmid.in_ready: got %b expected 1", inReady); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rstmid.busy: got %b expected 0", busy); end
    #3 rst = 1'b1;
    @(posedge clk); #1;
    pushPair(8'd21, 8'd14);
    for (int c = 0; c < 40 && !outValid; c++) begin @(posedge clk); #1; end
    tests++;
    if (!outValid || outA !== 8'd21 || outB !== 8'd14 || outRes !== 8'd7) begin
      fails++; $display("[TB] FAIL rstmid.fresh: got valid=%b %0d,%0d->%0d expected 1 21,14->7", outValid, outA, outB, outRes);
    end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rstmid.stale_work: busy=%b expected 0", busy); end
  endtask

  task automatic test_spurious_done();
    outReady = 1'b1;
    spurDone = 1'b1;
    @(posedge clk); #1;
    spurDone = 1'b0;
    tests++; if (outValid !== 1'b0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL spur.idle_empty: valid=%b busy=%b expected 0/0", outValid, busy); end
    pushPair(8'd35, 8'd14);
    spurDone = 1'b1;
    @(posedge clk); #1;
    tests++; if (gcdStart !== 1'b1) begin fails++; $display("[TB] FAIL spur.issue: got start=%b expected 1", gcdStart); end
    @(posedge clk); #1;
    spurDone = 1'b0;
    tests++; if (outValid !== 1'b0) begin fails++; $display("[TB] FAIL spur.in_issue: got valid=%b expected 0", outValid); end
    for (int c = 0; c < 40 && !outValid; c++) begin @(posedge clk); #1; end
    tests++;
    if (!outValid || outRes !== 8'd7 || outA !== 8'd35) begin
      fails++; $display("[TB] FAIL spur.result: got valid=%b a=%0d res=%0d expected 1,35,7", outValid, outA, outRes);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    inValid = 1'b0;
    inA = '0;
    inB = '0;
    outReady = 1'b0;
    spurDone = 1'b0;
    test_reset();
    test_single_pair();
    test_zero_bypass();
    test_full_fifo();
    test_backpressure();
    test_reset_mid();
    test_spurious_done();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
